// File: rtl/clock_pkg.sv
// Shared types, limits and the BCD step helper for the BCD clock front panel.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HOUR = 2'd1;
  localparam logic [1:0] FS_MIN  = 2'd2;
  localparam logic [1:0] FS_SEC  = 2'd3;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  localparam int FIELD_W  = 8;
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  // One BCD step within 00..vmax with wrap; an illegal input snaps to 00.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] vmax,
                                          input logic up);
    logic [3:0] tens, ones;
    logic [7:0] res;
    tens = v[7:4];
    ones = v[3:0];
    if (tens > 4'd9 || ones > 4'd9 || v > vmax)
      res = 8'h00;
    else if (up) begin
      if (v == vmax)        res = 8'h00;
      else if (ones == 4'd9) res = {tens + 4'd1, 4'd0};
      else                   res = {tens, ones + 4'd1};
    end else begin
      if (v == 8'h00)        res = vmax;
      else if (ones == 4'd0) res = {tens - 4'd1, 4'd9};
      else                   res = {tens, ones - 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability filter, one-cycle press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;
  logic          w_accept;

  // The DEB_CYCLES-th consecutive differing sample commits the new level.
  assign w_accept = (r_sync[1] != r_level) && (r_cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= w_accept && r_sync[1];
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_setter.sv
// Front-panel time-setting controller: edits hour/minute/second of a BCD clock
// and hands the result back with a one-cycle load strobe.
module time_setter #(
  parameter int         DEB_CYCLES = 500000,
  parameter int         BLINK_DIV  = 12500000,
  parameter logic [7:0] HOUR_MAX   = 8'h23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [23:0] cur_time,
  output logic        en,
  output logic        load,
  output logic [23:0] cin,
  output logic [1:0]  field_sel,
  output logic        blank
);

  import clock_pkg::*;

  localparam int BW = $clog2(BLINK_DIV + 1);

  logic          w_p_mode, w_p_inc, w_p_dec;
  logic          w_step;
  state_e        r_state, w_state_nxt;
  logic [23:0]   r_edit, w_edit_nxt;
  logic          r_load, w_load_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blank;
  logic [7:0]    w_hour_nxt, w_min_nxt, w_sec_nxt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .i_btn(btn_mode), .o_pulse(w_p_mode));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .rst(rst), .i_btn(btn_inc), .o_pulse(w_p_inc));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk(clk), .rst(rst), .i_btn(btn_dec), .o_pulse(w_p_dec));

  // A field edit needs exactly one of inc/dec and loses to a mode press.
  assign w_step = (w_p_inc ^ w_p_dec) && !w_p_mode && (r_state != RUN);

  assign w_hour_nxt = bcd_step(r_edit[HOUR_LSB +: FIELD_W], HOUR_MAX, w_p_inc);
  assign w_min_nxt  = bcd_step(r_edit[MIN_LSB  +: FIELD_W], MIN_MAX,  w_p_inc);
  assign w_sec_nxt  = bcd_step(r_edit[SEC_LSB  +: FIELD_W], SEC_MAX,  w_p_inc);

  always_comb begin
    w_state_nxt = r_state;
    w_edit_nxt  = r_edit;
    w_load_nxt  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_p_mode) begin
          w_state_nxt = SET_H;
          w_edit_nxt  = cur_time;
        end
      end
      SET_H: begin
        if (w_p_mode)    w_state_nxt = SET_M;
        else if (w_step) w_edit_nxt[HOUR_LSB +: FIELD_W] = w_hour_nxt;
      end
      SET_M: begin
        if (w_p_mode)    w_state_nxt = SET_S;
        else if (w_step) w_edit_nxt[MIN_LSB +: FIELD_W] = w_min_nxt;
      end
      SET_S: begin
        if (w_p_mode) begin
          w_state_nxt = RUN;
          w_load_nxt  = 1'b1;
        end else if (w_step) begin
          w_edit_nxt[SEC_LSB +: FIELD_W] = w_sec_nxt;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_edit  <= 24'h000000;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_edit  <= w_edit_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Blink restarts on any state change or accepted edit so the field stays lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_state == RUN || w_state_nxt != r_state || w_step) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blank     <= ~r_blank;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_comb begin
    field_sel = FS_NONE;
    case (r_state)
      SET_H:   field_sel = FS_HOUR;
      SET_M:   field_sel = FS_MIN;
      SET_S:   field_sel = FS_SEC;
      default: field_sel = FS_NONE;
    endcase
  end

  assign en    = (r_state == RUN);
  assign load  = r_load;
  assign cin   = r_edit;
  assign blank = r_blank;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: press-table vectors plus corner sequences,
// with load strobes checked against a scoreboard queue.
module tb_time_setter;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec;
  logic [23:0] cur_time;
  logic        en, load, blank;
  logic [23:0] cin;
  logic [1:0]  field_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int n_loads = 0;
  logic [23:0] load_q[$];

  always #5 clk = ~clk;

  time_setter #(.DEB_CYCLES(4), .BLINK_DIV(8), .HOUR_MAX(8'h23)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_time(cur_time), .en(en), .load(load), .cin(cin), .field_sel(field_sel),
    .blank(blank));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every load strobe must match the next queued expectation, one cycle each.
  always @(negedge clk) begin
    if (load === 1'b1) begin
      n_loads++;
      if (load_q.size() == 0) chk("load_unexpected", 32'(load), 32'h0);
      else chk("load_cin", 32'(cin), 32'(load_q.pop_front()));
    end
  end

  typedef struct {
    logic [23:0] ct;
    logic        m, i, d;
    logic [1:0]  sel;
    logic [23:0] cin;
    logic        ld;
  } vec_t;

  vec_t vecs[32];

  task automatic press(input logic m, input logic i, input logic d);
    @(posedge clk); #1;
    btn_mode = m; btn_inc = i; btn_dec = d;
    repeat (8) @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  initial begin
    bit seen;
    bit changed;
    vecs = '{
      '{24'h235958, 1'b1, 1'b0, 1'b0, 2'd1, 24'h235958, 1'b0},
      '{24'h235958, 1'b0, 1'b1, 1'b0, 2'd1, 24'h005958, 1'b0},
      '{24'h235958, 1'b1, 1'b0, 1'b0, 2'd2, 24'h005958, 1'b0},
      '{24'h235958, 1'b1, 1'b0, 1'b0, 2'd3, 24'h005958, 1'b0},
      '{24'h235958, 1'b0, 1'b1, 1'b0, 2'd3, 24'h005959, 1'b0},
      '{24'h235958, 1'b0, 1'b1, 1'b0, 2'd3, 24'h005900, 1'b0},
      '{24'h235958, 1'b1, 1'b0, 1'b0, 2'd0, 24'h005900, 1'b1},
      '{24'h120005, 1'b1, 1'b0, 1'b0, 2'd1, 24'h120005, 1'b0},
      '{24'h120005, 1'b1, 1'b0, 1'b0, 2'd2, 24'h120005, 1'b0},
      '{24'h120005, 1'b0, 1'b0, 1'b1, 2'd2, 24'h125905, 1'b0},
      '{24'h120005, 1'b0, 1'b1, 1'b0, 2'd2, 24'h120005, 1'b0},
      '{24'h120005, 1'b0, 1'b0, 1'b1, 2'd2, 24'h125905, 1'b0},
      '{24'h120005, 1'b1, 1'b0, 1'b0, 2'd3, 24'h125905, 1'b0},
      '{24'h120005, 1'b0, 1'b0, 1'b1, 2'd3, 24'h125904, 1'b0},
      '{24'h120005, 1'b1, 1'b0, 1'b0, 2'd0, 24'h125904, 1'b1},
      '{24'h071030, 1'b1, 1'b0, 1'b0, 2'd1, 24'h071030, 1'b0},
      '{24'h071030, 1'b0, 1'b0, 1'b1, 2'd1, 24'h061030, 1'b0},
      '{24'h071030, 1'b1, 1'b1, 1'b0, 2'd2, 24'h061030, 1'b0},
      '{24'h071030, 1'b0, 1'b1, 1'b1, 2'd2, 24'h061030, 1'b0},
      '{24'h071030, 1'b0, 1'b0, 1'b1, 2'd2, 24'h060930, 1'b0},
      '{24'h071030, 1'b1, 1'b0, 1'b0, 2'd3, 24'h060930, 1'b0},
      '{24'h071030, 1'b0, 1'b1, 1'b0, 2'd3, 24'h060931, 1'b0},
      '{24'h071030, 1'b1, 1'b0, 1'b0, 2'd0, 24'h060931, 1'b1},
      '{24'h071030, 1'b0, 1'b1, 1'b0, 2'd0, 24'h060931, 1'b0},
      '{24'h000000, 1'b1, 1'b0, 1'b0, 2'd1, 24'h000000, 1'b0},
      '{24'h000000, 1'b0, 1'b0, 1'b1, 2'd1, 24'h230000, 1'b0},
      '{24'h000000, 1'b1, 1'b0, 1'b0, 2'd2, 24'h230000, 1'b0},
      '{24'h000000, 1'b1, 1'b0, 1'b0, 2'd3, 24'h230000, 1'b0},
      '{24'h000000, 1'b1, 1'b0, 1'b0, 2'd0, 24'h230000, 1'b1},
      '{24'h245900, 1'b1, 1'b0, 1'b0, 2'd1, 24'h245900, 1'b0},
      '{24'h245900, 1'b0, 1'b1, 1'b0, 2'd1, 24'h005900, 1'b0},
      '{24'h245900, 1'b1, 1'b0, 1'b0, 2'd2, 24'h005900, 1'b0}
    };

    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; cur_time = 24'h235958;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("idle_en", 32'(en), 32'h1);
      chk("idle_load", 32'(load), 32'h0);
      chk("idle_cin", 32'(cin), 32'h0);
      chk("idle_sel", 32'(field_sel), 32'h0);
      chk("idle_blank", 32'(blank), 32'h0);
    end

    for (int v = 0; v < 32; v++) begin
      cur_time = vecs[v].ct;
      if (vecs[v].ld) load_q.push_back(vecs[v].cin);
      press(vecs[v].m, vecs[v].i, vecs[v].d);
      @(negedge clk);
      chk($sformatf("vec%0d_sel", v), 32'(field_sel), 32'(vecs[v].sel));
      chk($sformatf("vec%0d_cin", v), 32'(cin), 32'(vecs[v].cin));
      chk($sformatf("vec%0d_en", v), 32'(en), 32'(vecs[v].sel == 2'd0));
    end

    // 3-cycle glitch on dec in SET_M must be filtered out.
    @(posedge clk); #1 btn_dec = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_dec = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("glitch_cin", 32'(cin), 32'h005900);
    chk("glitch_sel", 32'(field_sel), 32'd2);

    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (blank) seen = 1'b1;
    end
    chk("blank_blinks", 32'(seen), 32'h1);

    // Accepted dec: blank must be 0 on the very cycle the field changes.
    @(posedge clk); #1 btn_dec = 1'b1;
    changed = 1'b0;
    for (int c = 0; c < 30 && !changed; c++) begin
      @(negedge clk);
      if (cin != 24'h005900) begin
        changed = 1'b1;
        chk("dec_blank_restart", 32'(blank), 32'h0);
      end
    end
    chk("dec_seen", 32'(changed), 32'h1);
    chk("dec_cin", 32'(cin), 32'h005800);
    #1 btn_dec = 1'b0;
    repeat (14) @(posedge clk);

    // Reset mid-edit discards the edit without a load.
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_sel", 32'(field_sel), 32'd0);
    chk("rst_cin", 32'(cin), 32'h0);
    chk("rst_en", 32'(en), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_cin", 32'(cin), 32'h0);
    chk("post_rst_en", 32'(en), 32'h1);
    chk("load_q_empty", 32'(load_q.size()), 32'h0);
    chk("load_count", 32'(n_loads), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_setter.md
# time_setter

Front-panel time-setting controller for the BCD clock. It debounces three push-buttons and walks a hours → minutes → seconds edit state machine, incrementing or decrementing the selected BCD field with wrap-around. It drives the clock's `en` and 24-bit `cin` preset, plus a one-cycle `load` strobe. It also flags the field under edit and a blink phase for the display stage. It sits directly upstream of the cascaded seconds/minutes/hours counter chain.

## Interface

Parameters:
- `DEB_CYCLES`, default 500000: cycles a synchronised button level must stay stable before it is accepted.
- `BLINK_DIV`, default 12500000: half-period of the blink phase, in cycles.
- `HOUR_MAX`, default 8'h23: BCD upper bound of the hour field.

Ports:
- `clk`  in  1: sole clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `btn_mode`  in  1: raw mode button, active-high, asynchronous.
- `btn_inc`  in  1: raw increment button, active-high, asynchronous.
- `btn_dec`  in  1: raw decrement button, active-high, asynchronous.
- `cur_time`  in  24: live clock value {hour_t,hour_o,min_t,min_o,sec_t,sec_o}.
- `en`  out  1: count enable to the clock; 1 only in RUN.
- `load`  out  1: one-cycle strobe; clock must take `cin` as its new value.
- `cin`  out  24: edited BCD time, same packing as `cur_time`.
- `field_sel`  out  2: 0 none, 1 hour, 2 minute, 3 second.
- `blank`  out  1: blink phase; display blanks the selected field when 1.

## Operation

- Each button passes through: 2-FF synchroniser → stability counter (accept after `DEB_CYCLES` identical samples) → rising-edge detector. Each press yields exactly one 1-cycle pulse: `p_mode`, `p_inc` or `p_dec`. Releases and bounces yield nothing.
- FSM states: RUN, SET_H, SET_M, SET_S.
- RUN + `p_mode` → SET_H. On that edge, `cur_time` is captured into the edit register.
- SET_H + `p_mode` → SET_M; SET_M + `p_mode` → SET_S.
- SET_S + `p_mode` → RUN. On that edge `load`=1 for exactly one cycle, with `cin` holding the edited value.
- `p_inc` / `p_dec` act only in SET_*, on the selected field:
  - Seconds and minutes: BCD +1 / −1 over 00..59. 59+1 → 00; 00−1 → 59.
  - Hour: 00..`HOUR_MAX`. `HOUR_MAX`+1 → 00; 00−1 → `HOUR_MAX`.
  - Units digit carries into the tens digit: 09+1 → 10; 10−1 → 09.
  - Other fields are untouched; there is no carry between fields.
- A captured field outside its legal range is forced to 00 on its first inc/dec.
- `cin` always shows the edit register. `en`=0 in every SET_* state, so the clock freezes.
- `blank` toggles every `BLINK_DIV` cycles in SET_* states; it is forced 0 in RUN.
- `blank` restarts at 0 on every state change and on every accepted `p_inc`/`p_dec`, so the field stays visible while it is adjusted.

## Timing

- Reset values: state RUN, `en`=1, `load`=0, `cin`=24'h000000, `field_sel`=0, `blank`=0. Debounce, synchroniser and blink counters clear to 0; filtered levels clear to 0.
- Press-to-pulse latency: 2 synchroniser cycles + `DEB_CYCLES` + 1 edge cycle.
- Pulse-to-output latency: 1 cycle. State, `field_sel`, `cin`, `en` and `load` all update on the edge that consumes the pulse.
- Simultaneous pulses:
  - `p_mode` with `p_inc`/`p_dec`: the mode change wins and the field edit is dropped.
  - `p_inc` with `p_dec`: both are ignored.
- Reset asserted mid-edit: immediate return to RUN, the edit is discarded, and `load` does not pulse.
- `load` never asserts except on the SET_S → RUN edge. `en` rises on that same edge.

## Structure

- Shared package `clock_pkg`:
  - State enum {RUN, SET_H, SET_M, SET_S}.
  - `field_sel` encodings.
  - BCD limits `SEC_MAX`/`MIN_MAX` = 8'h59.
  - Field bit-slice constants for the 24-bit time word.
- Sub-module `btn_debounce`: synchroniser, stability counter and edge pulse, parameterised by `DEB_CYCLES`. It is instantiated three times.
- BCD inc/dec logic is a function in `clock_pkg`, shared by all three fields.

## Test plan

Bench uses `DEB_CYCLES`=4 and `BLINK_DIV`=8.

- Reset, then idle 50 cycles → `en`=1, `load`=0, `cin`=000000, `field_sel`=0, `blank`=0 throughout.
- `cur_time`=235958, mode press, then 1× inc → state SET_H, `cin`=235958 then `cin`=005958 (hour wraps 23 → 00), `en`=0.
- Mode ×2 into SET_S from `cin`=005958, then 2× inc → `cin`=005900. Mode → `load`=1 for exactly one cycle with `cin`=005900, then `en`=1.
- In SET_M with minutes 00, dec → 59. Then 10 → dec → 09 (tens borrow). A 3-cycle glitch on `btn_dec` produces no change.
- Same-cycle mode+inc in SET_H → advances to SET_M, hour unchanged. Same-cycle inc+dec → no change.
- Reset pulse while in SET_M with modified `cin` → RUN, `cin`=000000, `en`=1, and no `load` pulse is observed.
